// File: rtl/multi_sync_filter_pkg.sv
// Shared defaults and helpers for the multi-channel synchroniser/glitch filter.
package multi_sync_filter_pkg;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int FILTER_CYCLES_DEF = 4;
    localparam int GLITCH_W_DEF      = 8;

    // Ceiling log2 with a floor of 1 bit, so a counter is never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/multi_sync_filter_glitch_filter_ch.sv
// One channel of the filter: persistence counter, registered edge pulses and, when
// MULTI_SYNC_FILTER_GLITCH_CNT_EN is defined, a saturating per-channel glitch counter.
module glitch_filter_ch
    import multi_sync_filter_pkg::*;
#(
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int GLITCH_W      = GLITCH_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_synced,
    output logic                o_filt,
    output logic                o_rise,
    output logic                o_fall
`ifdef MULTI_SYNC_FILTER_GLITCH_CNT_EN
    ,
    input  logic                i_glitch_clr,
    output logic [GLITCH_W-1:0] o_glitch_cnt
`endif
);

    localparam int               CNT_W    = clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
        $error("glitch_filter_ch: FILTER_CYCLES must be at least 1");
    end
    if (GLITCH_W < 1) begin : g_bad_glitch_w
        $error("glitch_filter_ch: GLITCH_W must be at least 1");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;
    logic             r_rise;
    logic             r_fall;
    logic             w_accept;

    // The new level has now been seen on FILTER_CYCLES consecutive samples.
    assign w_accept = (i_synced != r_filt) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every flop here samples pre-edge values.
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_accept & i_synced;
            r_fall <= w_accept & ~i_synced;
            if ((i_synced == r_filt) || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_filt <= i_synced;
            end
        end
    end

    assign o_filt = r_filt;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

`ifdef MULTI_SYNC_FILTER_GLITCH_CNT_EN
    logic                w_glitch;
    logic [GLITCH_W-1:0] r_glitch_cnt;

    // A pending change that collapsed back to the filtered level before acceptance.
    assign w_glitch = (i_synced == r_filt) && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || i_glitch_clr) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != '1)) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign o_glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: rtl/multi_sync_filter.sv
// Multi-channel CDC receiver: SYNC_STAGES flop synchroniser per bit, then a per-channel
// glitch filter. Define MULTI_SYNC_FILTER_GLITCH_CNT_EN to add glitch counters.
module multi_sync_filter
    import multi_sync_filter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int GLITCH_W      = GLITCH_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          async_in,
    output logic [WIDTH-1:0]          filt_out,
    output logic [WIDTH-1:0]          rise_pulse,
    output logic [WIDTH-1:0]          fall_pulse
`ifdef MULTI_SYNC_FILTER_GLITCH_CNT_EN
    ,
    input  logic                      glitch_clr,
    output logic [WIDTH*GLITCH_W-1:0] glitch_cnt
`endif
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("multi_sync_filter: SYNC_STAGES must be at least 2");
    end

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_synced;

    // Plain flop chain with nothing between stages, to give metastability time to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every stage is reset, not just the last, so no pre-reset sample can
            // reach the filter after release.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        glitch_filter_ch #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .GLITCH_W      (GLITCH_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_synced     (w_synced[i]),
            .o_filt       (filt_out[i]),
            .o_rise       (rise_pulse[i]),
            .o_fall       (fall_pulse[i])
`ifdef MULTI_SYNC_FILTER_GLITCH_CNT_EN
            ,
            .i_glitch_clr (glitch_clr),
            .o_glitch_cnt (glitch_cnt[i*GLITCH_W +: GLITCH_W])
`endif
        );
    end

endmodule
